// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a w x h sprite from a synchronous ROM into a 640x480 frame buffer,
// skipping transparent and off-screen pixels and stalling on a withheld write grant.
`default_nettype none

module sprite_blitter #(
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned FB_ADDR_W   = 19,
   parameter int unsigned SPR_ADDR_W  = 12,
   parameter logic [7:0]  TRANSPARENT = 8'h00
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [9:0]            spr_x,
   input  logic [9:0]            spr_y,
   input  logic [6:0]            spr_w,
   input  logic [6:0]            spr_h,
   input  logic [SPR_ADDR_W-1:0] spr_base,
   output logic                  busy,
   output logic                  done,
   output logic [SPR_ADDR_W-1:0] rom_addr,
   input  logic [7:0]            rom_data,
   output logic                  fb_we,
   output logic [FB_ADDR_W-1:0]  fb_addr,
   output logic [7:0]            fb_data,
   input  logic                  fb_grant
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_WRITE  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                  state_q;
   logic [9:0]              x_q, y_q;
   logic [6:0]              w_q, h_q;
   logic [6:0]              col_q, row_q;
   logic [6:0]              col_d, row_d;
   logic [SPR_ADDR_W-1:0]   rom_addr_q;
   logic [FB_ADDR_W-1:0]    fb_addr_q;
   logic                    vis_q;
   logic                    busy_q;
   logic                    done_q;

   logic [10:0]             w_px, w_py;
   logic                    w_visible;
   logic                    w_opaque;
   logic                    w_col_last;
   logic                    w_last_pixel;
   logic [FB_ADDR_W-1:0]    w_pix_addr;

   always_comb begin
      w_px         = {1'b0, x_q} + {4'b0000, col_q};
      w_py         = {1'b0, y_q} + {4'b0000, row_q};
      w_visible    = (w_px < 11'(SCREEN_W)) && (w_py < 11'(SCREEN_H));
      w_pix_addr   = FB_ADDR_W'(w_py) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(w_px);
      w_opaque     = (rom_data != TRANSPARENT);
      w_col_last   = (col_q == w_q - 7'd1);
      w_last_pixel = w_col_last && (row_q == h_q - 7'd1);
      col_d        = w_col_last ? 7'd0 : col_q + 7'd1;
      row_d        = w_col_last ? row_q + 7'd1 : row_q;
   end

   // Visibility and address are captured in READ so WRITE only has to look at the ROM data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         w_q        <= '0;
         h_q        <= '0;
         col_q      <= '0;
         row_q      <= '0;
         rom_addr_q <= '0;
         fb_addr_q  <= '0;
         vis_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (start) begin
                  x_q        <= spr_x;
                  y_q        <= spr_y;
                  w_q        <= spr_w;
                  h_q        <= spr_h;
                  col_q      <= '0;
                  row_q      <= '0;
                  rom_addr_q <= spr_base;
                  busy_q     <= 1'b1;
                  if (spr_w == 7'd0 || spr_h == 7'd0) begin
                     state_q <= S_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               fb_addr_q <= w_pix_addr;
               vis_q     <= w_visible;
               state_q   <= S_WRITE;
            end
            S_WRITE: begin
               if (!(vis_q && w_opaque && !fb_grant)) begin
                  if (w_last_pixel) begin
                     state_q <= S_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     // Row-major order makes the ROM address a plain running increment.
                     col_q      <= col_d;
                     row_q      <= row_d;
                     rom_addr_q <= rom_addr_q + SPR_ADDR_W'(1);
                     state_q    <= S_READ;
                  end
               end
            end
            S_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rom_addr = rom_addr_q;
   assign fb_addr  = fb_addr_q;
   assign fb_data  = (state_q == S_WRITE) ? rom_data : 8'h00;
   assign fb_we    = (state_q == S_WRITE) && vis_q && w_opaque && fb_grant && !Reset;

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized and directed checks of sprite_blitter against a per-pixel
// reference model of the blit (write list, timing, stalls, clipping and reset abort).
`default_nettype none

module tb_sprite_blitter;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  spr_x = '0, spr_y = '0;
   logic [6:0]  spr_w = '0, spr_h = '0;
   logic [11:0] spr_base = '0;
   logic        busy, done, fb_we;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data = '0;
   logic [18:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_grant = 1'b1;

   sprite_blitter dut (
      .Clk(Clk), .Reset(Reset), .start(start),
      .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_base(spr_base),
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_grant(fb_grant)
   );

   always #5 Clk = ~Clk;

   logic [7:0] rom_mem [0:4095];
   always @(posedge Clk) rom_data <= rom_mem[rom_addr];

   int vectors = 0, miscompares = 0;
   int wr_addr[$], wr_data[$], exp_addr[$], exp_data[$];
   int st_addr[$], st_data[$], st_we[$];
   int done_cnt = 0, busy_cnt = 0, grant_viol = 0;
   int grant_mode = 0, stall_left = 0, stall_addr = 0;

   // Observer: records frame-buffer writes, done pulses and busy cycles.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (fb_we) begin
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_data));
         end
         if (fb_we && !fb_grant) grant_viol++;
         if (done) done_cnt++;
         else if (busy) busy_cnt++;
         if (grant_mode == 2 && busy && !fb_grant) begin
            st_addr.push_back(int'(fb_addr));
            st_data.push_back(int'(fb_data));
            st_we.push_back(int'(fb_we));
         end
      end
   end

   // Grant driver: always granted, random, or a scripted stall on one target address.
   always @(posedge Clk) begin
      #1;
      if (grant_mode == 1)
         fb_grant = ($urandom_range(0, 3) != 0);
      else if (grant_mode == 2 && stall_left > 0 && int'(fb_addr) == stall_addr && wr_addr.size() == 1) begin
         fb_grant = 1'b0;
         stall_left--;
      end else
         fb_grant = 1'b1;
   end

   task automatic clear_mon();
      wr_addr.delete(); wr_data.delete();
      st_addr.delete(); st_data.delete(); st_we.delete();
      done_cnt = 0; busy_cnt = 0; grant_viol = 0;
   endtask

   // Reference: every visible, non-zero pixel in raster order, address py*640+px.
   task automatic model_blit(input int x, input int y, input int w, input int h, input int base);
      exp_addr.delete(); exp_data.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            int px, py, d;
            px = x + c; py = y + r;
            d = int'(rom_mem[(base + r * w + c) % 4096]);
            if (px < 640 && py < 480 && d != 0) begin
               exp_addr.push_back(py * 640 + px);
               exp_data.push_back(d);
            end
         end
   endtask

   task automatic run_blit(input int x, input int y, input int w, input int h, input int base,
                           input int budget, output bit ok);
      int n;
      clear_mon();
      spr_x = 10'(x); spr_y = 10'(y); spr_w = 7'(w); spr_h = 7'(h); spr_base = 12'(base);
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge Clk);
         n++;
      end
      ok = (done_cnt != 0);
      repeat (3) @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we: got %0b expected 0", fb_we); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
      vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
      vectors++; if (fb_addr !== 19'd0) begin miscompares++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
      vectors++; if (fb_data !== 8'd0) begin miscompares++; $display("FAIL reset_fb_data: got %0d expected 0", fb_data); end
      Reset = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_directed(input string name, input int x, input int y, input int w, input int h,
                                input int exp_busy);
      bit ok;
      model_blit(x, y, w, h, 0);
      run_blit(x, y, w, h, 0, 200, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL %s_timeout: no done within bound", name); end
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL %s_done: got %0d pulses expected 1", name, done_cnt); end
      vectors++; if (busy_cnt != exp_busy) begin miscompares++; $display("FAIL %s_busy: got %0d cycles expected %0d", name, busy_cnt, exp_busy); end
      vectors++; if (grant_viol != 0) begin miscompares++; $display("FAIL %s_grant: got %0d ungranted writes expected 0", name, grant_viol); end
      vectors++;
      if (wr_addr.size() != exp_addr.size()) begin
         miscompares++; $display("FAIL %s_nwrites: got %0d expected %0d", name, wr_addr.size(), exp_addr.size());
      end
      foreach (exp_addr[i]) if (i < wr_addr.size()) begin
         vectors++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            miscompares++;
            $display("FAIL %s_write%0d: got (%0d,%0d) expected (%0d,%0d)", name, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) rom_mem[i] = 8'(i + 1);
      test_directed("basic", 10, 20, 2, 2, 8);
      vectors++; if (exp_addr.size() != 4 || exp_addr[0] != 12810) begin miscompares++; $display("FAIL basic_model: got %0d expected 12810", exp_addr[0]); end
   endtask

   task automatic test_transparent();
      rom_mem[0] = 8'd5; rom_mem[1] = 8'd0; rom_mem[2] = 8'd7;
      test_directed("transparent", 0, 0, 3, 1, 6);
   endtask

   task automatic test_clip();
      for (int i = 0; i < 4; i++) rom_mem[i] = 8'd9;
      test_directed("clip", 639, 479, 2, 2, 8);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 4; i++) rom_mem[i] = 8'(i + 1);
      grant_mode = 2; stall_left = 5; stall_addr = 20 * 640 + 11;
      test_directed("stall", 10, 20, 2, 2, 13);
      grant_mode = 0;
      vectors++; if (st_addr.size() != 5) begin miscompares++; $display("FAIL stall_len: got %0d stalled cycles expected 5", st_addr.size()); end
      foreach (st_addr[i]) begin
         vectors++;
         if (st_addr[i] != 12811 || st_data[i] != 2 || st_we[i] != 0) begin
            miscompares++;
            $display("FAIL stall_hold%0d: got (%0d,%0d,we=%0d) expected (12811,2,we=0)", i, st_addr[i], st_data[i], st_we[i]);
         end
      end
   endtask

   task automatic test_zero();
      test_directed("zero_w", 5, 5, 0, 5, 0);
      test_directed("zero_h", 5, 5, 3, 0, 0);
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 4096; i++) rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      clear_mon();
      model_blit(50, 60, 3, 2, 100);
      spr_x = 10'd50; spr_y = 10'd60; spr_w = 7'd3; spr_h = 7'd2; spr_base = 12'd100;
      start = 1'b1;
      @(posedge Clk); #1;
      n = 0;
      while (done_cnt == 0 && n < 60) begin
         if (n >= 2 && n < 6) begin
            start = 1'b1; spr_x = 10'd200; spr_w = 7'd5; spr_base = 12'd7;
         end else start = 1'b0;
         @(posedge Clk); #1;
         n++;
      end
      start = 1'b0;
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL b2b_done: got %0d pulses expected 1", done_cnt); end
      vectors++; if (wr_addr.size() != exp_addr.size()) begin miscompares++; $display("FAIL b2b_nwrites: got %0d expected %0d", wr_addr.size(), exp_addr.size()); end
      foreach (exp_addr[i]) if (i < wr_addr.size()) begin
         vectors++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            miscompares++; $display("FAIL b2b_write%0d: got (%0d,%0d) expected (%0d,%0d)", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
      // Now in the IDLE cycle right after done: a new start must be accepted.
      clear_mon();
      model_blit(10, 10, 2, 3, 300);
      spr_x = 10'd10; spr_y = 10'd10; spr_w = 7'd2; spr_h = 7'd3; spr_base = 12'd300;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart: got busy=%0b expected 1", busy); end
      n = 0;
      while (done_cnt == 0 && n < 60) begin @(negedge Clk); n++; end
      repeat (2) @(posedge Clk);
      #1;
      vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL b2b2_done: got %0d pulses expected 1", done_cnt); end
      vectors++; if (wr_addr.size() != exp_addr.size()) begin miscompares++; $display("FAIL b2b2_nwrites: got %0d expected %0d", wr_addr.size(), exp_addr.size()); end
      foreach (exp_addr[i]) if (i < wr_addr.size()) begin
         vectors++;
         if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            miscompares++; $display("FAIL b2b2_write%0d: got (%0d,%0d) expected (%0d,%0d)", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      for (int i = 0; i < 16; i++) rom_mem[500 + i] = 8'(8'h30 + i);
      clear_mon();
      spr_x = 10'd100; spr_y = 10'd100; spr_w = 7'd4; spr_h = 7'd4; spr_base = 12'd500;
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         @(posedge Clk); #1;
         if (fb_we && wr_addr.size() >= 2) found = 1'b1;
      end
      vectors++; if (!found) begin miscompares++; $display("FAIL rmid_reach: got no write cycle expected one within bound"); end
      Reset = 1'b1;
      #1;
      vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL rmid_fb_we: got %0b expected 0", fb_we); end
      @(posedge Clk); #1;
      vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL rmid_flags: got busy/done=%0b expected 00", {busy, done}); end
      vectors++; if (rom_addr !== 12'd0 || fb_addr !== 19'd0 || fb_data !== 8'd0) begin
         miscompares++; $display("FAIL rmid_outputs: got rom=%0d fb=%0d data=%0d expected 0/0/0", rom_addr, fb_addr, fb_data);
      end
      Reset = 1'b0;
      clear_mon();
      repeat (10) @(posedge Clk);
      #1;
      vectors++; if (done_cnt != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_abort: got done=%0d busy=%0b expected 0/0", done_cnt, busy); end
      model_blit(100, 100, 4, 4, 500);
      begin
         bit ok;
         run_blit(100, 100, 4, 4, 500, 200, ok);
         vectors++; if (!ok || done_cnt != 1) begin miscompares++; $display("FAIL rmid_rerun_done: got %0d pulses expected 1", done_cnt); end
         vectors++; if (wr_addr != exp_addr || wr_data != exp_data) begin
            miscompares++; $display("FAIL rmid_rerun_writes: got %0d writes expected %0d matching", wr_addr.size(), exp_addr.size());
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int x, y, w, h, base;
         bit ok;
         x    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023) : $urandom_range(625, 645);
         y    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023) : $urandom_range(465, 485);
         w    = $urandom_range(0, 10);
         h    = $urandom_range(0, 10);
         base = $urandom_range(3990, 4095);
         grant_mode = 1;
         model_blit(x, y, w, h, base);
         run_blit(x, y, w, h, base, 2000, ok);
         grant_mode = 0;
         vectors++; if (!ok || done_cnt != 1) begin miscompares++; $display("FAIL rand%0d_done: got %0d pulses expected 1", it, done_cnt); end
         vectors++; if (grant_viol != 0) begin miscompares++; $display("FAIL rand%0d_grant: got %0d ungranted writes expected 0", it, grant_viol); end
         vectors++; if (busy_cnt < 2 * w * h) begin miscompares++; $display("FAIL rand%0d_busy: got %0d cycles expected at least %0d", it, busy_cnt, 2 * w * h); end
         vectors++;
         if (wr_addr.size() != exp_addr.size()) begin
            miscompares++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", it, wr_addr.size(), exp_addr.size());
         end
         foreach (exp_addr[i]) if (i < wr_addr.size()) begin
            vectors++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
               miscompares++;
               $display("FAIL rand%0d_write%0d: got (%0d,%0d) expected (%0d,%0d)", it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
      test_reset();
      test_basic();
      test_transparent();
      test_clip();
      test_stall();
      test_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
